flopoco_fdiv_4_3: RTL and testbench
===================================

# flopoco_fdiv_4_3

Iterative floating-point divider for the 10-bit FloPoCo format (2-bit exception, sign, wE=4, wF=3, bias 7) used by the existing `fmul` core. It computes R = X / Y with round-to-nearest-even using a restoring radix-2 significand divider, so it trades throughput for area. It sits beside `fmul` in the datapath library and uses valid/ready handshakes at both ends so the scheduler can stall it.

## Interface
- `ID`, 1, instance tag; no functional effect, matches `fmul`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: X/Y operands present.
- `in_ready` output 1: divider can accept an operand pair.
- `X` input 10: dividend, layout {exc[9:8], sign[7], exp[6:3], frac[2:0]}.
- `Y` input 10: divisor, same layout.
- `out_valid` output 1: R holds a result.
- `out_ready` input 1: consumer takes R.
- `R` output 10: quotient, same layout.

## Operation
- Exception codes: 00 zero, 01 normal, 10 infinity, 11 NaN.
- Sign is always sX ^ sY, including for zero, infinity and NaN results.
- Exception table, first match wins:
  - NaN if either operand is NaN, or for 0/0 and inf/inf.
  - Infinity for inf/(normal or 0) and normal/0.
  - Zero for 0/(normal or inf) and normal/inf.
  - Otherwise both operands are normal and the result goes through the divider.
- All exception results set R[6:0] = 0.
- Normal path:
  - Exponent: e = {00,eX} − {00,eY} + 7, 6-bit two's complement.
  - Significands: sigX = {1,fX}, sigY = {1,fY}. Remainder register is 6 bits and starts at sigX.
  - Each DIV cycle: if rem ≥ sigY, the quotient bit is 1 and rem −= sigY; otherwise the bit is 0. Then rem <<= 1. There are 6 iterations, giving q[5:0], MSB first.
  - If q[5]=1: mant = q[4:2], guard = q[1], sticky = q[0] | (rem≠0), exponent unchanged.
  - If q[5]=0: mant = q[3:1], guard = q[0], sticky = (rem≠0), e −= 1.
  - Rounding: round = guard & (sticky | mant[0]). The 9-bit value {e, mant} + round is the rounded result, written {e', mant'}.
  - Post-round classification on e'[5:4]: 00 gives normal, with R = {01, sign, e'[3:0], mant'}. 01 gives infinity (overflow). 1x gives zero (underflow). Both of those zero R[6:0].
- FSM states: IDLE, DIV, ROUND, DONE.
  - IDLE: `in_ready`=1. When in_valid & in_ready, latch the operands. Go to DIV for the normal path, or to DONE with R loaded for an exceptional pair.
  - DIV: a 3-bit counter runs 0..5. Leave for ROUND after count 5.
  - ROUND: load R, go to DONE.
  - DONE: `out_valid`=1 and R is held stable. When out_valid & out_ready, go to IDLE.
- `in_ready` is high only in IDLE. There is no overlap of operations; the input is ignored while busy.

## Timing
- Reset values: state IDLE, `out_valid`=0, R=0, so `in_ready`=1. All internal registers are cleared.
- Normal path: `out_valid` rises 8 cycles after the accepting edge (6 DIV + 1 ROUND + 1 into DONE).
- Exceptional path: `out_valid` rises on the cycle after the accepting edge.
- Minimum issue interval is 9 cycles for the normal path and 2 for exceptions, assuming `out_ready` is held high.
- R and `out_valid` are registered; there is no combinational path from inputs to outputs. `in_ready` decodes the state only.
- Asserting rst_n mid-operation aborts the operation with no output; `out_valid` drops immediately.
- Holding `out_ready` low keeps DONE indefinitely with R unchanged.

## Structure
- Package `flopoco_fp_pkg` holds:
  - constants WE=4, WF=3, BIAS=7;
  - exception enum EXC_ZERO/EXC_NORMAL/EXC_INF/EXC_NAN;
  - FSM state enum;
  - field-extraction functions for exc, sign, exp and frac.
- Sub-module `flopoco_fdiv_sigcore` is the restoring divider:
  - inputs: start, sigX, sigY;
  - outputs: q[5:0], rem_nz, done;
  - it owns the counter and remainder.
- The top level holds the exception decode, exponent arithmetic, rounding and handshake FSM.

## Test plan
- 1.0/1.0: X=0x138, Y=0x138, out_ready=1 → R=0x138; `out_valid` 8 cycles after accept, one cycle wide.
- Exact and signed results:
  - 3.0/2.0: X=0x144, Y=0x140 → R=0x13C.
  - −3.0/2.0: X=0x1C4 → R=0x1BC.
- Rounding: 1.0/1.5, X=0x138, Y=0x13C → q=010101 with a nonzero remainder, round up → R=0x133 (0.6875).
- Exceptions:
  - X=0x138, Y=0x000 → R=0x200.
  - X=0x000, Y=0x000 → R=0x300.
  - X=0x300, Y=0x138 → R=0x300.
  - Each with `out_valid` one cycle after accept.
- Range limits:
  - Overflow: X=0x17F, Y=0x100 → R=0x200.
  - Underflow: X=0x100, Y=0x178 → R=0x000.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles after `out_valid` → R stable, in_ready=0; a new operand offered during that time is not accepted.
  - Pull rst_n low in DIV cycle 3 → `out_valid`=0 at once, in_ready=1 after release, and the next 1.0/1.0 completes correctly.

Source files
------------

// File: rtl/flopoco_fp_pkg.sv
// Shared FloPoCo 10-bit float definitions: {exc[1:0], sign, exp[3:0], frac[2:0]}.
// Field helpers keep the bit positions in one place for fmul/fdiv.
package flopoco_fp_pkg;

    localparam int WE    = 4;
    localparam int WF    = 3;
    localparam int BIAS  = 7;
    localparam int FP_W  = 3 + WE + WF;
    localparam int SIG_W = WF + 1;
    localparam int Q_W   = WF + 3;
    localparam int REM_W = WF + 3;

    typedef enum logic [1:0] {
        EXC_ZERO   = 2'b00,
        EXC_NORMAL = 2'b01,
        EXC_INF    = 2'b10,
        EXC_NAN    = 2'b11
    } exc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_ROUND,
        ST_DONE
    } state_t;

    function automatic exc_t fp_exc(input logic [FP_W-1:0] x);
        return exc_t'(x[FP_W-1 -: 2]);
    endfunction

    function automatic logic fp_sign(input logic [FP_W-1:0] x);
        return x[WE+WF];
    endfunction

    function automatic logic [WE-1:0] fp_exp(input logic [FP_W-1:0] x);
        return x[WE+WF-1:WF];
    endfunction

    function automatic logic [WF-1:0] fp_frac(input logic [FP_W-1:0] x);
        return x[WF-1:0];
    endfunction

endpackage

// File: rtl/flopoco_fdiv_sigcore.sv
// Restoring radix-2 significand divider: one quotient bit per cycle, Q_W cycles.
// start loads the remainder with sig_x; done marks the edge producing the last bit.
module flopoco_fdiv_sigcore
    import flopoco_fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SIG_W-1:0] sig_x,
    input  logic [SIG_W-1:0] sig_y,
    output logic [Q_W-1:0]   q,
    output logic             rem_nz,
    output logic             done
);

    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] diff;
    logic [Q_W-1:0]   q_r;
    logic [2:0]       cnt;
    logic             busy;
    logic             ge;

    assign ge   = rem >= {2'b00, sig_y};
    assign diff = rem - {2'b00, sig_y};

    // rem stays below 2*sig_y, so the shifted-out MSB is always zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  <= '0;
            q_r  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rem  <= {2'b00, sig_x};
            q_r  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            rem  <= ge ? {diff[REM_W-2:0], 1'b0} : {rem[REM_W-2:0], 1'b0};
            q_r  <= {q_r[Q_W-2:0], ge};
            cnt  <= cnt + 3'd1;
            if (cnt == 3'(Q_W - 1))
                busy <= 1'b0;
        end
    end

    assign q      = q_r;
    assign rem_nz = |rem;
    assign done   = busy && (cnt == 3'(Q_W - 1));

endmodule

// File: rtl/flopoco_fdiv_4_3.sv
// FloPoCo (wE=4, wF=3) divider R = X / Y, round-to-nearest-even, one operation
// in flight; exceptional operand pairs bypass the significand divider.
module flopoco_fdiv_4_3
    import flopoco_fp_pkg::*;
#(
    parameter logic ID = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] X,
    input  logic [FP_W-1:0] Y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] R
);

    state_t          state, state_nx;
    exc_t            exc_x, exc_y, exc_res;
    logic            accept, sign_in, sign_q;
    logic [5:0]      exp_in, exp_q, exp_n;
    logic [FP_W-1:0] r_q, r_norm;
    logic [Q_W-1:0]  q;
    logic            rem_nz, core_done;
    logic [WF-1:0]   mant;
    logic            guard, sticky, rnd;
    logic [8:0]      rsum;
    logic            unused_id;

    assign unused_id = ID;
    assign exc_x     = fp_exc(X);
    assign exc_y     = fp_exc(Y);
    assign sign_in   = fp_sign(X) ^ fp_sign(Y);
    assign exp_in    = {2'b00, fp_exp(X)} - {2'b00, fp_exp(Y)} + 6'(BIAS);
    assign accept    = in_valid && (state == ST_IDLE);

    // first match wins: NaN, then infinity, then zero
    always_comb begin
        exc_res = EXC_NORMAL;
        if (exc_x == EXC_NAN || exc_y == EXC_NAN ||
            (exc_x == EXC_ZERO && exc_y == EXC_ZERO) ||
            (exc_x == EXC_INF && exc_y == EXC_INF))
            exc_res = EXC_NAN;
        else if (exc_x == EXC_INF || exc_y == EXC_ZERO)
            exc_res = EXC_INF;
        else if (exc_x == EXC_ZERO || exc_y == EXC_INF)
            exc_res = EXC_ZERO;
    end

    flopoco_fdiv_sigcore u_sigcore (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && exc_res == EXC_NORMAL),
        .sig_x  ({1'b1, fp_frac(X)}),
        .sig_y  ({1'b1, fp_frac(Y)}),
        .q      (q),
        .rem_nz (rem_nz),
        .done   (core_done)
    );

    // a mantissa carry out of the rounding add propagates into the exponent
    always_comb begin
        if (q[Q_W-1]) begin
            mant   = q[4:2];
            guard  = q[1];
            sticky = q[0] | rem_nz;
            exp_n  = exp_q;
        end else begin
            mant   = q[3:1];
            guard  = q[0];
            sticky = rem_nz;
            exp_n  = exp_q - 6'd1;
        end
        rnd  = guard & (sticky | mant[0]);
        rsum = {exp_n, mant} + {8'd0, rnd};
        case (rsum[8:7])
            2'b00:   r_norm = {EXC_NORMAL, sign_q, rsum[6:0]};
            2'b01:   r_norm = {EXC_INF, sign_q, 7'd0};
            default: r_norm = {EXC_ZERO, sign_q, 7'd0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
            r_q    <= '0;
        end else if (accept) begin
            sign_q <= sign_in;
            exp_q  <= exp_in;
            if (exc_res != EXC_NORMAL)
                r_q <= {exc_res, sign_in, 7'd0};
        end else if (state == ST_ROUND) begin
            r_q <= r_norm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (in_valid) state_nx = (exc_res == EXC_NORMAL) ? ST_DIV : ST_DONE;
            ST_DIV:   if (core_done) state_nx = ST_ROUND;
            ST_ROUND: state_nx = ST_DONE;
            ST_DONE:  if (out_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    assign R = r_q;

endmodule

// File: tb/tb_flopoco_fdiv_4_3.sv
// Self-checking bench for flopoco_fdiv_4_3: directed cases, handshake/reset
// scenarios and random operands against a value-level reference model.
module tb_flopoco_fdiv_4_3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [9:0] X = '0;
    logic [9:0] Y = '0;
    logic       in_ready, out_valid;
    logic [9:0] R;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    flopoco_fdiv_4_3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // value-level model: exact quotient to 5 fraction bits, RNE to 3 bits
    function automatic logic [9:0] ref_div(input logic [9:0] x, input logic [9:0] y);
        int xe, ye, s, sx, sy, e, num, q, sh, m, drop, half;
        bit rnz;
        logic [3:0] e4;
        logic [2:0] m3;
        xe = int'(x[9:8]); ye = int'(y[9:8]); s = int'(x[7] ^ y[7]);
        if (xe == 3 || ye == 3 || (xe == 0 && ye == 0) || (xe == 2 && ye == 2))
            return {2'b11, s[0], 7'd0};
        if (xe == 2 || ye == 0) return {2'b10, s[0], 7'd0};
        if (xe == 0 || ye == 2) return {2'b00, s[0], 7'd0};
        sx  = 8 + int'(x[2:0]);
        sy  = 8 + int'(y[2:0]);
        e   = int'(x[6:3]) - int'(y[6:3]) + 7;
        num = sx * 32;
        q   = num / sy;
        rnz = (num % sy) != 0;
        if (q >= 32) sh = 2;
        else begin sh = 1; e = e - 1; end
        m    = q >> sh;
        drop = q & ((1 << sh) - 1);
        half = 1 << (sh - 1);
        if (drop > half || (drop == half && (rnz || (m % 2) == 1))) m = m + 1;
        if (m == 16) begin m = 8; e = e + 1; end
        if (e > 15) return {2'b10, s[0], 7'd0};
        if (e < 0)  return {2'b00, s[0], 7'd0};
        e4 = e[3:0];
        m3 = m[2:0];
        return {2'b01, s[0], e4, m3};
    endfunction

    // called at a negedge; returns on the negedge where out_valid is first seen
    task automatic issue(input logic [9:0] x, input logic [9:0] y, output int lat);
        int g = 0;
        while (!in_ready && g < 50) begin @(negedge clk); g++; end
        X = x; Y = y; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 99;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = i; break; end
        end
    endtask

    task automatic run(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [9:0] exp_r, input int exp_lat);
        int lat;
        issue(x, y, lat);
        chk({tag, " lat"}, lat, exp_lat);
        chk({tag, " R"}, R, exp_r);
        @(negedge clk);
        chk({tag, " ov_width"}, out_valid, 0);
        chk({tag, " rdy_after"}, in_ready, 1);
    endtask

    logic [9:0] dx   [9] = '{10'h138, 10'h144, 10'h1C4, 10'h138, 10'h138, 10'h000, 10'h300, 10'h17F, 10'h100};
    logic [9:0] dy   [9] = '{10'h138, 10'h140, 10'h140, 10'h13C, 10'h000, 10'h000, 10'h138, 10'h100, 10'h178};
    logic [9:0] dr   [9] = '{10'h138, 10'h13C, 10'h1BC, 10'h133, 10'h200, 10'h300, 10'h300, 10'h200, 10'h000};
    int         dlat [9] = '{8, 8, 8, 8, 1, 1, 1, 8, 8};

    function automatic logic [9:0] rnd_op();
        logic [7:0] v;
        logic [1:0] e;
        v = 8'($urandom);
        e = ($urandom_range(0, 9) < 8) ? 2'b01 : 2'($urandom_range(0, 3));
        return {e, v};
    endfunction

    initial begin
        int lat;
        logic [9:0] x, y;
        repeat (3) @(negedge clk);
        chk("rst out_valid", out_valid, 0);
        chk("rst R", R, 0);
        chk("rst in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run($sformatf("dir%0d", i), dx[i], dy[i], dr[i], dlat[i]);

        // consumer stall: result held, new operands refused
        out_ready = 1'b0;
        issue(10'h144, 10'h140, lat);
        chk("hold lat", lat, 8);
        for (int i = 0; i < 5; i++) begin
            X = 10'h300; Y = 10'h300; in_valid = 1'b1;
            @(negedge clk);
            chk("hold R", R, 10'h13C);
            chk("hold in_ready", in_ready, 0);
            chk("hold out_valid", out_valid, 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("hold release ov", out_valid, 0);
        chk("hold release rdy", in_ready, 1);
        @(negedge clk);
        chk("hold no accept ov", out_valid, 0);

        // reset in the middle of the divide
        X = 10'h138; Y = 10'h138; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst R", R, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst in_ready", in_ready, 1);
        run("post_rst", 10'h138, 10'h138, 10'h138, 8);

        for (int i = 0; i < 300; i++) begin
            x = rnd_op();
            y = rnd_op();
            issue(x, y, lat);
            chk($sformatf("rnd%0d %h/%h R", i, x, y), R, ref_div(x, y));
            chk($sformatf("rnd%0d lat", i), lat, (x[9:8] == 2'b01 && y[9:8] == 2'b01) ? 8 : 1);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
